mc_control_unit: RTL and testbench
==================================

Name: mc_control_unit

Overview:
- Multicycle control FSM for the MIPS-subset datapath.
- Sequences fetch, decode, execute, memory and writeback, and drives every datapath select and write enable, including mux_regDest_control (rt / rd / $31).
- Sits beside the datapath top. Reads opcode/funct from the instruction register and zero/overflow from the ALU.
- Waits a parameterised number of cycles on memory.

Parameters:
- MEM_LAT, 2, extra wait cycles for a memory read (legal 0..7). A read occupies MEM_LAT+1 cycles.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- overflow  in  1  ALU overflow flag
- pc_write  out  1  PC load enable
- ir_write  out  1  IR load enable
- mdr_write  out  1  MDR load enable
- alu_out_write  out  1  ALUOut load enable
- mem_wr  out  1  memory write strobe
- iord  out  1  memory address select: 0=PC, 1=ALUOut
- reg_write  out  1  register-file write enable
- mux_regDest_control  out  2  00=rt, 01=rd, 10=$31
- mux_memToReg_control  out  2  00=ALUOut, 01=MDR, 10=PC
- alu_srcA  out  1  0=PC, 1=A
- alu_srcB  out  2  00=B, 01=const 4, 10=sext(imm), 11=sext(imm)<<2
- alu_op  out  3  000=pass A, 001=add, 010=sub, 011=and
- pc_source  out  2  00=ALU result, 01=ALUOut, 10=jump target, 11=exception vector
- epc_write  out  1  EPC load enable (loads ALU result)
- exc_cause  out  1  0=invalid opcode/funct, 1=overflow; valid while epc_write=1

Behaviour:
- Outputs are Moore, decoded from the registered state and wait counter. Every enable and select not listed for a state is 0.
- Reset is synchronous. With reset=1 at an edge: state <= RESET and counter <= 0. All outputs are 0 during RESET. The next state after RESET is FETCH.
- Reset mid-instruction aborts the instruction. No write enable is asserted in the cycle after reset is sampled.
- FETCH (MEM_LAT+1 cycles): iord=0, srcA=0, srcB=01, alu_op=001. The counter counts 0..MEM_LAT. Only on the last cycle are ir_write=1 and pc_write=1 (pc_source=00). Then go to DECODE.
- DECODE (1 cycle): srcA=0, srcB=11, alu_op=001, alu_out_write=1 (branch target). Dispatch on opcode:
  - 0x00 with funct 0x20, 0x22 or 0x24 -> EXEC_R
  - 0x00 with funct 0x08 -> JR
  - 0x08 -> ADDI_EX
  - 0x23 or 0x2B -> ADDR
  - 0x04 or 0x05 -> BRANCH
  - 0x02 -> JUMP
  - 0x03 -> JAL
  - anything else -> EXCEPT with cause 0
- EXEC_R: srcA=1, srcB=00, alu_op=001/010/011 per funct, alu_out_write=1. If overflow is set on add/sub -> EXCEPT with cause 1. Otherwise -> WB_R.
- WB_R: reg_write=1, regDest=01, memToReg=00. Then FETCH.
- ADDI_EX: srcA=1, srcB=10, alu_op=001, alu_out_write=1. Overflow -> EXCEPT with cause 1. Otherwise -> ADDI_WB.
- ADDI_WB: reg_write=1, regDest=00, memToReg=00. Then FETCH.
- ADDR: srcA=1, srcB=10, alu_op=001, alu_out_write=1. Go to MEM_RD for lw, MEM_WR for sw.
- MEM_RD (MEM_LAT+1 cycles): iord=1. mdr_write=1 on the last cycle only. Then LW_WB.
- LW_WB: reg_write=1, regDest=00, memToReg=01. Then FETCH.
- MEM_WR (1 cycle): iord=1, mem_wr=1. Then FETCH.
- BRANCH: srcA=1, srcB=00, alu_op=010, pc_source=01.
  - beq: pc_write = zero.
  - bne: pc_write = !zero.
  - Then FETCH.
- JR: srcA=1, alu_op=000, pc_source=00, pc_write=1. Then FETCH.
- JUMP: pc_source=10, pc_write=1. Then FETCH.
- JAL: pc_source=10, pc_write=1, reg_write=1, regDest=10, memToReg=10. $31 receives the already-incremented PC (PC+4). Then FETCH.
- EXCEPT: srcA=0, srcB=01, alu_op=010 (PC-4), epc_write=1, exc_cause held from entry, pc_source=11, pc_write=1. No reg_write. Then FETCH.
- Latency per instruction = (MEM_LAT+1) + 1 + execute states. With MEM_LAT=2: R-type 6, addi 6, lw 9, sw 6, beq/bne/j/jal/jr 5 cycles.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state encoding (RESET, FETCH, DECODE, EXEC_R, WB_R, ADDI_EX, ADDI_WB, ADDR, MEM_RD, LW_WB, MEM_WR, BRANCH, JR, JUMP, JAL, EXCEPT)
  - opcode and funct constants
  - all select encodings (regDest, memToReg, srcB, alu_op, pc_source)
- One sub-module, mem_wait_counter:
  - 3-bit counter with clear, enable and done = (count == MEM_LAT)
  - shared by FETCH and MEM_RD

Test Plan:
- Reset held 3 cycles, then released -> all outputs 0 through the cycle after release; FETCH follows; pc_write/ir_write first rise 3 cycles later (MEM_LAT=2).
- add (op 0x00, funct 0x20, overflow=0) -> WB_R in cycle 6 with reg_write=1, regDest=01, memToReg=00; back to FETCH.
- lw (0x23) -> mdr_write in cycle 8; LW_WB in cycle 9 with regDest=00, memToReg=01; iord=1 during cycles 6-8.
- jal (0x03) -> cycle 5: pc_write=1, pc_source=10, reg_write=1, regDest=10, memToReg=10.
- beq with zero=0, then bne with zero=0 -> pc_write 0 then 1 in the BRANCH cycle; pc_source=01 in both.
- addi with overflow=1 -> EXCEPT with epc_write=1, exc_cause=1, pc_source=11 and no reg_write. Opcode 0x3F -> EXCEPT with exc_cause=0.
- Reset asserted during MEM_RD -> RESET next cycle; mdr_write and reg_write never asserted.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg
// Shared definitions for the multicycle MIPS-subset control unit:
//   - FSM state encoding
//   - opcode / funct constants
//   - datapath select encodings (register destination, write-back source,
//     ALU operand B, ALU operation, PC source)
//   - the control-word struct and the per-state control decode function
// No ports; imported with "import mc_ctrl_pkg::*".
package mc_ctrl_pkg;

  // FSM states
  typedef enum logic [3:0] {
    RESET   = 4'd0,
    FETCH   = 4'd1,
    DECODE  = 4'd2,
    EXEC_R  = 4'd3,
    WB_R    = 4'd4,
    ADDI_EX = 4'd5,
    ADDI_WB = 4'd6,
    ADDR    = 4'd7,
    MEM_RD  = 4'd8,
    LW_WB   = 4'd9,
    MEM_WR  = 4'd10,
    BRANCH  = 4'd11,
    JR      = 4'd12,
    JUMP    = 4'd13,
    JAL     = 4'd14,
    EXCEPT  = 4'd15
  } state_t;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;

  // Register destination select
  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  // Write-back data select
  localparam logic [1:0] MTR_ALUOUT = 2'b00;
  localparam logic [1:0] MTR_MDR    = 2'b01;
  localparam logic [1:0] MTR_PC     = 2'b10;

  // ALU operand A select
  localparam logic SRCA_PC = 1'b0;
  localparam logic SRCA_A  = 1'b1;

  // ALU operand B select
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // ALU operation
  localparam logic [2:0] ALU_PASSA = 3'b000;
  localparam logic [2:0] ALU_ADD   = 3'b001;
  localparam logic [2:0] ALU_SUB   = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;

  // PC source select
  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;
  localparam logic [1:0] PCS_EXC    = 2'b11;

  // Complete control word. br_eq / br_ne are not datapath outputs: they
  // mark a BRANCH cycle so the top can qualify pc_write with the live
  // ALU zero flag, which only settles inside that cycle.
  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       mdr_write;
    logic       alu_out_write;
    logic       mem_wr;
    logic       iord;
    logic       reg_write;
    logic [1:0] reg_dest;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       epc_write;
    logic       exc_cause;
    logic       br_eq;
    logic       br_ne;
  } ctrl_t;

  // Control word for a state. 'last' is the wait-counter terminal flag for
  // that cycle; 'cause' is the exception cause latched on entry to EXCEPT.
  function automatic ctrl_t decode_ctrl(input state_t     st,
                                        input logic       last,
                                        input logic [5:0] opcode,
                                        input logic [5:0] funct,
                                        input logic       cause);
    ctrl_t c;
    c = '0;
    case (st)
      RESET: begin
        c = '0;
      end
      FETCH: begin
        c.iord      = 1'b0;
        c.alu_src_a = SRCA_PC;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALU_ADD;
        c.pc_source = PCS_ALU;
        if (last) begin
          c.ir_write = 1'b1;
          c.pc_write = 1'b1;
        end else begin
          c.ir_write = 1'b0;
          c.pc_write = 1'b0;
        end
      end
      DECODE: begin
        // Precompute the branch target while the opcode is decoded.
        c.alu_src_a     = SRCA_PC;
        c.alu_src_b     = SRCB_IMM_SH;
        c.alu_op        = ALU_ADD;
        c.alu_out_write = 1'b1;
      end
      EXEC_R: begin
        c.alu_src_a     = SRCA_A;
        c.alu_src_b     = SRCB_B;
        c.alu_out_write = 1'b1;
        case (funct)
          FN_SUB:  c.alu_op = ALU_SUB;
          FN_AND:  c.alu_op = ALU_AND;
          default: c.alu_op = ALU_ADD;
        endcase
      end
      WB_R: begin
        c.reg_write  = 1'b1;
        c.reg_dest   = RD_RD;
        c.mem_to_reg = MTR_ALUOUT;
      end
      ADDI_EX, ADDR: begin
        c.alu_src_a     = SRCA_A;
        c.alu_src_b     = SRCB_IMM;
        c.alu_op        = ALU_ADD;
        c.alu_out_write = 1'b1;
      end
      ADDI_WB: begin
        c.reg_write  = 1'b1;
        c.reg_dest   = RD_RT;
        c.mem_to_reg = MTR_ALUOUT;
      end
      MEM_RD: begin
        c.iord      = 1'b1;
        c.mdr_write = last;
      end
      LW_WB: begin
        c.reg_write  = 1'b1;
        c.reg_dest   = RD_RT;
        c.mem_to_reg = MTR_MDR;
      end
      MEM_WR: begin
        c.iord   = 1'b1;
        c.mem_wr = 1'b1;
      end
      BRANCH: begin
        c.alu_src_a = SRCA_A;
        c.alu_src_b = SRCB_B;
        c.alu_op    = ALU_SUB;
        c.pc_source = PCS_ALUOUT;
        c.br_eq     = (opcode == OP_BEQ);
        c.br_ne     = (opcode == OP_BNE);
      end
      JR: begin
        c.alu_src_a = SRCA_A;
        c.alu_op    = ALU_PASSA;
        c.pc_source = PCS_ALU;
        c.pc_write  = 1'b1;
      end
      JUMP: begin
        c.pc_source = PCS_JUMP;
        c.pc_write  = 1'b1;
      end
      JAL: begin
        // PC already holds PC+4 from FETCH, so it is the link value.
        c.pc_source  = PCS_JUMP;
        c.pc_write   = 1'b1;
        c.reg_write  = 1'b1;
        c.reg_dest   = RD_RA;
        c.mem_to_reg = MTR_PC;
      end
      EXCEPT: begin
        // ALU forms PC-4 (address of the faulting instruction) for EPC.
        c.alu_src_a = SRCA_PC;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALU_SUB;
        c.epc_write = 1'b1;
        c.exc_cause = cause;
        c.pc_source = PCS_EXC;
        c.pc_write  = 1'b1;
      end
      default: begin
        c = '0;
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_control_unit_mem_wait_counter.sv
// mem_wait_counter
// 3-bit wait counter shared by the FETCH and MEM_RD states.
// Ports:
//   clk       in   system clock
//   reset     in   synchronous, active-high; count <= 0
//   clear     in   synchronous clear (count <= 0 next cycle)
//   enable    in   increment when not clearing
//   done      out  count == MEM_LAT this cycle
//   done_next out  count will equal MEM_LAT next cycle (lets the FSM
//                  register its outputs one cycle ahead)
module mem_wait_counter #(
  parameter int MEM_LAT = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic done,
  output logic done_next
);

  localparam logic [2:0] LAST = 3'(MEM_LAT);

  logic [2:0] count;
  logic [2:0] count_next;

  // Next count: clear wins over enable.
  always_comb begin
    if (clear) begin
      count_next = 3'd0;
    end else if (enable) begin
      count_next = count + 3'd1;
    end else begin
      count_next = count;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= 3'd0;
    end else begin
      count <= count_next;
    end
  end

  assign done      = (count == LAST);
  assign done_next = (count_next == LAST);

endmodule

// File: rtl/mc_control_unit.sv
// mc_control_unit
// Multicycle control FSM for the MIPS-subset datapath. Sequences fetch,
// decode, execute, memory and write-back and drives every datapath enable
// and select. Memory reads (FETCH, MEM_RD) last MEM_LAT+1 cycles.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   opcode, funct               IR[31:26], IR[5:0]
//   zero, overflow              ALU flags
//   pc_write, ir_write, mdr_write, alu_out_write, mem_wr, iord,
//   reg_write, epc_write        write enables / memory controls
//   mux_regDest_control         00=rt 01=rd 10=$31
//   mux_memToReg_control        00=ALUOut 01=MDR 10=PC
//   alu_srcA, alu_srcB, alu_op  ALU operand and operation selects
//   pc_source                   00=ALU 01=ALUOut 10=jump 11=exc vector
//   exc_cause                   0=invalid instr, 1=overflow (with epc_write)
// All outputs are registered, computed from the next state, except that
// pc_write in BRANCH is qualified by the live zero flag.
module mc_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_LAT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mdr_write,
  output logic       alu_out_write,
  output logic       mem_wr,
  output logic       iord,
  output logic       reg_write,
  output logic [1:0] mux_regDest_control,
  output logic [1:0] mux_memToReg_control,
  output logic       alu_srcA,
  output logic [1:0] alu_srcB,
  output logic [2:0] alu_op,
  output logic [1:0] pc_source,
  output logic       epc_write,
  output logic       exc_cause
);

  state_t state;
  state_t next_state;
  logic   next_cause;
  ctrl_t  ctrl;
  ctrl_t  ctrl_next;

  logic in_wait;
  logic cnt_enable;
  logic cnt_clear;
  logic cnt_done;
  logic cnt_done_next;

  // The counter runs only while a wait state is still short of its last
  // cycle; otherwise it is held at zero so every wait state starts at 0.
  assign in_wait    = (state == FETCH) || (state == MEM_RD);
  assign cnt_enable = in_wait && !cnt_done;
  assign cnt_clear  = !cnt_enable;

  mem_wait_counter #(
    .MEM_LAT (MEM_LAT)
  ) u_wait (
    .clk       (clk),
    .reset     (reset),
    .clear     (cnt_clear),
    .enable    (cnt_enable),
    .done      (cnt_done),
    .done_next (cnt_done_next)
  );

  // Next-state and exception-cause selection.
  always_comb begin
    next_state = state;
    next_cause = 1'b0;
    case (state)
      RESET: begin
        next_state = FETCH;
      end
      FETCH: begin
        if (cnt_done) begin
          next_state = DECODE;
        end else begin
          next_state = FETCH;
        end
      end
      DECODE: begin
        case (opcode)
          OP_RTYPE: begin
            case (funct)
              FN_ADD, FN_SUB, FN_AND: next_state = EXEC_R;
              FN_JR:                  next_state = JR;
              default:                next_state = EXCEPT;
            endcase
          end
          OP_ADDI:       next_state = ADDI_EX;
          OP_LW, OP_SW:  next_state = ADDR;
          OP_BEQ, OP_BNE: next_state = BRANCH;
          OP_J:          next_state = JUMP;
          OP_JAL:        next_state = JAL;
          default:       next_state = EXCEPT;
        endcase
      end
      EXEC_R: begin
        // 'and' cannot overflow, so only add/sub trap.
        if (overflow && ((funct == FN_ADD) || (funct == FN_SUB))) begin
          next_state = EXCEPT;
          next_cause = 1'b1;
        end else begin
          next_state = WB_R;
        end
      end
      ADDI_EX: begin
        if (overflow) begin
          next_state = EXCEPT;
          next_cause = 1'b1;
        end else begin
          next_state = ADDI_WB;
        end
      end
      ADDR: begin
        if (opcode == OP_LW) begin
          next_state = MEM_RD;
        end else begin
          next_state = MEM_WR;
        end
      end
      MEM_RD: begin
        if (cnt_done) begin
          next_state = LW_WB;
        end else begin
          next_state = MEM_RD;
        end
      end
      WB_R, ADDI_WB, LW_WB, MEM_WR, BRANCH, JR, JUMP, JAL, EXCEPT: begin
        next_state = FETCH;
      end
      default: begin
        next_state = RESET;
      end
    endcase
  end

  // Control word for the cycle that next_state will occupy.
  assign ctrl_next = decode_ctrl(next_state, cnt_done_next, opcode, funct, next_cause);

  // State register and registered control outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RESET;
      ctrl  <= '0;
    end else begin
      state <= next_state;
      ctrl  <= ctrl_next;
    end
  end

  assign pc_write             = ctrl.pc_write | (ctrl.br_eq & zero) | (ctrl.br_ne & ~zero);
  assign ir_write             = ctrl.ir_write;
  assign mdr_write            = ctrl.mdr_write;
  assign alu_out_write        = ctrl.alu_out_write;
  assign mem_wr               = ctrl.mem_wr;
  assign iord                 = ctrl.iord;
  assign reg_write            = ctrl.reg_write;
  assign mux_regDest_control  = ctrl.reg_dest;
  assign mux_memToReg_control = ctrl.mem_to_reg;
  assign alu_srcA             = ctrl.alu_src_a;
  assign alu_srcB             = ctrl.alu_src_b;
  assign alu_op               = ctrl.alu_op;
  assign pc_source            = ctrl.pc_source;
  assign epc_write            = ctrl.epc_write;
  assign exc_cause            = ctrl.exc_cause;

endmodule

// File: tb/tb_mc_control_unit.sv
// Testbench for mc_control_unit: directed and random instructions compared
// cycle by cycle against an instruction-level reference model.
module tb_mc_control_unit;

  localparam int MEM_LAT = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       overflow;
  logic       pc_write, ir_write, mdr_write, alu_out_write, mem_wr, iord, reg_write;
  logic [1:0] mux_regDest_control, mux_memToReg_control;
  logic       alu_srcA;
  logic [1:0] alu_srcB;
  logic [2:0] alu_op;
  logic [1:0] pc_source;
  logic       epc_write, exc_cause;

  always #5 clk = ~clk;

  mc_control_unit #(.MEM_LAT(MEM_LAT)) dut (
    .clk                  (clk),
    .reset                (reset),
    .opcode               (opcode),
    .funct                (funct),
    .zero                 (zero),
    .overflow             (overflow),
    .pc_write             (pc_write),
    .ir_write             (ir_write),
    .mdr_write            (mdr_write),
    .alu_out_write        (alu_out_write),
    .mem_wr               (mem_wr),
    .iord                 (iord),
    .reg_write            (reg_write),
    .mux_regDest_control  (mux_regDest_control),
    .mux_memToReg_control (mux_memToReg_control),
    .alu_srcA             (alu_srcA),
    .alu_srcB             (alu_srcB),
    .alu_op               (alu_op),
    .pc_source            (pc_source),
    .epc_write            (epc_write),
    .exc_cause            (exc_cause)
  );

  typedef struct packed {
    logic       pc_write, ir_write, mdr_write, alu_out_write, mem_wr, iord, reg_write;
    logic [1:0] reg_dest;
    logic [1:0] mem_to_reg;
    logic       src_a;
    logic [1:0] src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       epc_write, exc_cause;
  } vec_t;

  vec_t obs;
  assign obs = {pc_write, ir_write, mdr_write, alu_out_write, mem_wr, iord, reg_write,
                mux_regDest_control, mux_memToReg_control, alu_srcA, alu_srcB,
                alu_op, pc_source, epc_write, exc_cause};

  int   checks   = 0;
  int   failures = 0;
  vec_t exp_q[$];

  task automatic check(input string tag, input vec_t want);
    checks++;
    assert (obs === want)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  function automatic vec_t v_except(input bit cause);
    vec_t e = '0;
    e.src_b = 2'b01; e.alu_op = 3'b010; e.epc_write = 1'b1;
    e.exc_cause = cause; e.pc_source = 2'b11; e.pc_write = 1'b1;
    return e;
  endfunction

  // Reference model: the full per-cycle control sequence of one instruction.
  task automatic build_expected(input logic [5:0] op, input logic [5:0] fn,
                                input bit z, input bit ov);
    vec_t e;
    exp_q.delete();
    for (int i = 0; i <= MEM_LAT; i++) begin
      e = '0; e.src_b = 2'b01; e.alu_op = 3'b001;
      if (i == MEM_LAT) begin e.pc_write = 1'b1; e.ir_write = 1'b1; end
      exp_q.push_back(e);
    end
    e = '0; e.src_b = 2'b11; e.alu_op = 3'b001; e.alu_out_write = 1'b1;
    exp_q.push_back(e);
    if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24)) begin
      e = '0; e.src_a = 1'b1; e.alu_out_write = 1'b1;
      e.alu_op = (fn == 6'h20) ? 3'b001 : ((fn == 6'h22) ? 3'b010 : 3'b011);
      exp_q.push_back(e);
      if (ov && fn != 6'h24) exp_q.push_back(v_except(1'b1));
      else begin
        e = '0; e.reg_write = 1'b1; e.reg_dest = 2'b01; exp_q.push_back(e);
      end
    end else if (op == 6'h00 && fn == 6'h08) begin
      e = '0; e.src_a = 1'b1; e.pc_write = 1'b1; exp_q.push_back(e);
    end else if (op == 6'h08) begin
      e = '0; e.src_a = 1'b1; e.src_b = 2'b10; e.alu_op = 3'b001; e.alu_out_write = 1'b1;
      exp_q.push_back(e);
      if (ov) exp_q.push_back(v_except(1'b1));
      else begin
        e = '0; e.reg_write = 1'b1; exp_q.push_back(e);
      end
    end else if (op == 6'h23 || op == 6'h2B) begin
      e = '0; e.src_a = 1'b1; e.src_b = 2'b10; e.alu_op = 3'b001; e.alu_out_write = 1'b1;
      exp_q.push_back(e);
      if (op == 6'h23) begin
        for (int i = 0; i <= MEM_LAT; i++) begin
          e = '0; e.iord = 1'b1; e.mdr_write = (i == MEM_LAT); exp_q.push_back(e);
        end
        e = '0; e.reg_write = 1'b1; e.mem_to_reg = 2'b01; exp_q.push_back(e);
      end else begin
        e = '0; e.iord = 1'b1; e.mem_wr = 1'b1; exp_q.push_back(e);
      end
    end else if (op == 6'h04 || op == 6'h05) begin
      e = '0; e.src_a = 1'b1; e.alu_op = 3'b010; e.pc_source = 2'b01;
      e.pc_write = (op == 6'h04) ? z : !z;
      exp_q.push_back(e);
    end else if (op == 6'h02 || op == 6'h03) begin
      e = '0; e.pc_source = 2'b10; e.pc_write = 1'b1;
      if (op == 6'h03) begin
        e.reg_write = 1'b1; e.reg_dest = 2'b10; e.mem_to_reg = 2'b10;
      end
      exp_q.push_back(e);
    end else begin
      exp_q.push_back(v_except(1'b0));
    end
  endtask

  // Drive one instruction and compare its first n cycles (n<0: all).
  task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                           input bit z, input bit ov, input int n);
    int lim;
    opcode = op; funct = fn; zero = z; overflow = ov;
    build_expected(op, fn, z, ov);
    lim = (n < 0) ? exp_q.size() : n;
    for (int k = 0; k < lim; k++) begin
      @(negedge clk);
      check($sformatf("%s_c%0d", tag, k + 1), exp_q[k]);
    end
  endtask

  logic [5:0] op_tab [0:10];
  logic [5:0] fn_tab [0:3];

  initial begin
    op_tab = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03, 6'h00};
    fn_tab = '{6'h20, 6'h22, 6'h24, 6'h08};
    reset = 1'b1; opcode = 6'h00; funct = 6'h00; zero = 1'b0; overflow = 1'b0;

    // Reset held three cycles; outputs idle throughout and after release.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("reset_c%0d", i + 1), '0);
    end
    reset = 1'b0;

    // Directed instructions.
    run_instr("add",       6'h00, 6'h20, 1'b0, 1'b0, -1);
    run_instr("lw",        6'h23, 6'h00, 1'b0, 1'b0, -1);
    run_instr("jal",       6'h03, 6'h00, 1'b0, 1'b0, -1);
    run_instr("beq_z0",    6'h04, 6'h00, 1'b0, 1'b0, -1);
    run_instr("bne_z0",    6'h05, 6'h00, 1'b0, 1'b0, -1);
    run_instr("beq_z1",    6'h04, 6'h00, 1'b1, 1'b0, -1);
    run_instr("addi_ovf",  6'h08, 6'h00, 1'b0, 1'b1, -1);
    run_instr("bad_op",    6'h3F, 6'h00, 1'b0, 1'b0, -1);
    run_instr("sub_ovf",   6'h00, 6'h22, 1'b0, 1'b1, -1);
    run_instr("and_ovf",   6'h00, 6'h24, 1'b0, 1'b1, -1);
    run_instr("bad_funct", 6'h00, 6'h21, 1'b0, 1'b0, -1);
    run_instr("sw",        6'h2B, 6'h00, 1'b0, 1'b0, -1);
    run_instr("j",         6'h02, 6'h00, 1'b0, 1'b0, -1);
    run_instr("jr",        6'h00, 6'h08, 1'b0, 1'b1, -1);
    run_instr("addi",      6'h08, 6'h00, 1'b1, 1'b0, -1);

    // Random instruction mix.
    for (int i = 0; i < 60; i++) begin
      logic [5:0] op, fn;
      op = op_tab[$urandom_range(0, 10)];
      fn = fn_tab[$urandom_range(0, 3)];
      if ($urandom_range(0, 7) == 0) op = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) fn = 6'($urandom_range(0, 63));
      run_instr($sformatf("rnd%0d_op%h_fn%h", i, op, fn), op, fn,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
    end

    // Reset during the first MEM_RD cycle of a lw aborts it.
    run_instr("lw_abort", 6'h23, 6'h00, 1'b0, 1'b0, MEM_LAT + 4);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check($sformatf("abort_reset_c%0d", i + 1), '0);
    end
    reset = 1'b0;
    run_instr("add_after_abort", 6'h00, 6'h20, 1'b0, 1'b0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
